// File: rtl/mips_core_pkg.sv
// Shared types and constants for the MIPS core's memory-side blocks.
//   read_sched_state_t : state encoding of the AXI read scheduler FSM
//   AXI_ID_WIDTH       : width of the AXI ARID/RID fields
//   AXI_LEN_WIDTH      : width of the AXI ARLEN field (bursts of 1..16 beats)
package mips_core_pkg;

  localparam int AXI_ID_WIDTH  = 4;
  localparam int AXI_LEN_WIDTH = 4;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_ADDR,
    RS_DATA
  } read_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority arbiter.
// Picks the first asserted request searching upward from ptr, wrapping
// around after N-1. Shared by the read scheduler and the future write
// scheduler.
//   req       : per-requester request bits
//   ptr       : index with highest priority this cycle
//   grant     : one-hot grant (all zero when nothing is requested)
//   grant_idx : binary index of the granted requester
//   any_req   : at least one request bit is set
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          found;

  // Walk the requesters in priority order (ptr, ptr+1, ...). The sum is one
  // bit wider than the index so the modulo-N wrap is a single subtract.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= N_W) begin
        sum = sum - N_W;
      end
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axi_read_scheduler.sv
// Round-robin scheduler sharing one external AXI read channel (AR + R)
// among READ_MASTERS cache refill requesters (0 = i_cache, 1 = d_cache).
// Exactly one burst is outstanding; the grant is held from address issue
// until the RLAST beat is handshaked.
//   clk, rst_n      : clock, synchronous active-low reset
//   m_arvalid/arlen/araddr, m_arready : per-master address request side
//   m_rvalid/m_rlast/m_rready, m_rdata : per-master data side (data broadcast)
//   ARVALID..ARADDR, ARREADY          : external AXI address channel
//   RVALID, RREADY, RLAST, RID, RDATA : external AXI data channel
//   busy      : a burst is in flight
//   rid_error : sticky, a handshaked beat carried an RID other than ARID
module axi_read_scheduler
  import mips_core_pkg::*;
#(
  parameter int READ_MASTERS = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [READ_MASTERS-1:0]              m_arvalid,
  input  logic [AXI_LEN_WIDTH*READ_MASTERS-1:0] m_arlen,
  input  logic [ADDR_WIDTH*READ_MASTERS-1:0]   m_araddr,
  output logic [READ_MASTERS-1:0]              m_arready,
  output logic [READ_MASTERS-1:0]              m_rvalid,
  output logic [READ_MASTERS-1:0]              m_rlast,
  output logic [DATA_WIDTH-1:0]                m_rdata,
  input  logic [READ_MASTERS-1:0]              m_rready,
  output logic                                 ARVALID,
  input  logic                                 ARREADY,
  output logic [AXI_ID_WIDTH-1:0]              ARID,
  output logic [AXI_LEN_WIDTH-1:0]             ARLEN,
  output logic [ADDR_WIDTH-1:0]                ARADDR,
  input  logic                                 RVALID,
  output logic                                 RREADY,
  input  logic                                 RLAST,
  input  logic [AXI_ID_WIDTH-1:0]              RID,
  input  logic [DATA_WIDTH-1:0]                RDATA,
  output logic                                 busy,
  output logic                                 rid_error
);

  localparam int IW = $clog2(READ_MASTERS);
  localparam logic [IW-1:0] LAST_IDX = IW'(READ_MASTERS - 1);

  read_sched_state_t state, state_next;

  logic [IW-1:0]            rr_ptr;
  logic [IW-1:0]            grant_q;
  logic [READ_MASTERS-1:0]  arb_grant;
  logic [IW-1:0]            arb_idx;
  logic                     arb_any;
  logic [AXI_LEN_WIDTH-1:0] sel_len;
  logic [ADDR_WIDTH-1:0]    sel_addr;
  logic                     r_hs;

  rr_arbiter #(
    .N  (READ_MASTERS),
    .IW (IW)
  ) u_arb (
    .req       (m_arvalid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Select the winning master's burst description with the one-hot grant.
  always_comb begin
    sel_len  = '0;
    sel_addr = '0;
    for (int i = 0; i < READ_MASTERS; i++) begin
      if (arb_grant[i]) begin
        sel_len  = m_arlen[AXI_LEN_WIDTH*i +: AXI_LEN_WIDTH];
        sel_addr = m_araddr[ADDR_WIDTH*i +: ADDR_WIDTH];
      end
    end
  end

  assign r_hs = RVALID && RREADY;

  // Next-state logic. Requests are only looked at in IDLE, so a request
  // arriving with the RLAST beat is granted the cycle after IDLE is entered.
  always_comb begin
    state_next = state;
    case (state)
      RS_IDLE: if (arb_any)        state_next = RS_ADDR;
      RS_ADDR: if (ARREADY)        state_next = RS_DATA;
      RS_DATA: if (r_hs && RLAST)  state_next = RS_IDLE;
      default:                     state_next = RS_IDLE;
    endcase
  end

  // State, grant bookkeeping and the latched AR fields. The AR fields are
  // captured once in IDLE, which keeps them stable under ARREADY backpressure
  // even if the master withdraws or changes its request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RS_IDLE;
      rr_ptr    <= '0;
      grant_q   <= '0;
      ARID      <= '0;
      ARLEN     <= '0;
      ARADDR    <= '0;
      rid_error <= 1'b0;
    end else begin
      state <= state_next;
      if (state == RS_IDLE && arb_any) begin
        grant_q <= arb_idx;
        ARID    <= AXI_ID_WIDTH'(arb_idx);
        ARLEN   <= sel_len;
        ARADDR  <= sel_addr;
      end
      if (state == RS_ADDR && ARREADY) begin
        rr_ptr <= (grant_q == LAST_IDX) ? '0 : grant_q + IW'(1);
      end
      if (state == RS_DATA && r_hs && (RID != ARID)) begin
        rid_error <= 1'b1;
      end
    end
  end

  // Per-master handshake routing; only the granted master sees anything.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_rlast   = '0;
    RREADY    = 1'b0;
    case (state)
      RS_ADDR: m_arready[grant_q] = ARREADY;
      RS_DATA: begin
        m_rvalid[grant_q] = RVALID;
        m_rlast[grant_q]  = RLAST;
        RREADY            = m_rready[grant_q];
      end
      default: ;
    endcase
  end

  assign ARVALID = (state == RS_ADDR);
  assign busy    = (state != RS_IDLE);
  assign m_rdata = RDATA;

endmodule

// File: tb/tb_axi_read_scheduler.sv
// Self-checking bench for axi_read_scheduler with four masters.
// Hand sequences cover the multi-cycle corner cases, a vector table covers
// round-robin priority, and a randomized run is checked against a
// request-pool model of the scheduling rules.
module tb_axi_read_scheduler;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_arvalid;
  logic [4*N-1:0]  m_arlen;
  logic [AW*N-1:0] m_araddr;
  logic [N-1:0]    m_arready;
  logic [N-1:0]    m_rvalid;
  logic [N-1:0]    m_rlast;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_rready;
  logic            ARVALID;
  logic            ARREADY;
  logic [3:0]      ARID;
  logic [3:0]      ARLEN;
  logic [AW-1:0]   ARADDR;
  logic            RVALID;
  logic            RREADY;
  logic            RLAST;
  logic [3:0]      RID;
  logic [DW-1:0]   RDATA;
  logic            busy;
  logic            rid_error;

  logic [AW-1:0] req_addr [N];
  logic [3:0]    req_len  [N];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          prev;
    logic [N-1:0] req;
    int          exp_grant;
  } arb_vec_t;

  arb_vec_t vecs [8];

  // Random-run model: pool of outstanding requests and round-robin pointer.
  bit            pend  [N];
  logic [AW-1:0] paddr [N];
  logic [3:0]    plen  [N];
  int            ptr_model;

  axi_read_scheduler #(
    .READ_MASTERS (N),
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_arvalid (m_arvalid),
    .m_arlen   (m_arlen),
    .m_araddr  (m_araddr),
    .m_arready (m_arready),
    .m_rvalid  (m_rvalid),
    .m_rlast   (m_rlast),
    .m_rdata   (m_rdata),
    .m_rready  (m_rready),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .ARID      (ARID),
    .ARLEN     (ARLEN),
    .ARADDR    (ARADDR),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .RLAST     (RLAST),
    .RID       (RID),
    .RDATA     (RDATA),
    .busy      (busy),
    .rid_error (rid_error)
  );

  always #5 clk = ~clk;

  // Pack the per-master request arrays onto the flat DUT buses.
  always_comb begin
    m_araddr = '0;
    m_arlen  = '0;
    for (int i = 0; i < N; i++) begin
      m_araddr[i*AW +: AW] = req_addr[i];
      m_arlen[i*4 +: 4]    = req_len[i];
    end
  end

  // Absolute bound on the run in case a handshake never completes.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int m);
    onehot = N'(1) << m;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_arvalid = '0;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    RLAST     = 1'b0;
    RID       = '0;
    RDATA     = '0;
    m_rready  = '1;
    for (int i = 0; i < N; i++) begin
      req_addr[i] = '0;
      req_len[i]  = '0;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] addr, input logic [3:0] len);
    req_addr[IW'(m)]  = addr;
    req_len[IW'(m)]   = len;
    m_arvalid[IW'(m)] = 1'b1;
  endtask

  // Waits (bounded) for ARVALID, checks the issued burst, applies 'stall'
  // cycles of ARREADY low, then the handshake. Leaves the DUT in DATA.
  task automatic addr_phase(input int m, input logic [AW-1:0] addr, input logic [3:0] len,
                            input int stall, input bit keep);
    bit ok;
    ok = 1'b0;
    ARREADY = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ARVALID === 1'b1) begin
        ok = 1'b1;
        break;
      end
      next_cycle();
    end
    checkOutput("arvalid_seen", 64'(ok), 64'(1));
    if (!ok) return;
    checkOutput("arid", 64'(ARID), 64'(m));
    checkOutput("araddr", 64'(ARADDR), 64'(addr));
    checkOutput("arlen", 64'(ARLEN), 64'(len));
    checkOutput("busy_addr", 64'(busy), 64'(1));
    for (int s = 0; s < stall; s++) begin
      #1;
      checkOutput("arready_stall", 64'(m_arready), 64'(0));
      checkOutput("arvalid_stall", 64'(ARVALID), 64'(1));
      checkOutput("araddr_stable", 64'(ARADDR), 64'(addr));
      checkOutput("arlen_stable", 64'(ARLEN), 64'(len));
      next_cycle();
    end
    ARREADY = 1'b1;
    #1;
    checkOutput("arready_grant", 64'(m_arready), 64'(onehot(m)));
    next_cycle();
    ARREADY = 1'b0;
    if (!keep) m_arvalid[IW'(m)] = 1'b0;
  endtask

  // Streams len+1 beats to master m, optionally with random RVALID gaps and
  // random m_rready stalls; a beat counts only when RVALID and m_rready[m].
  task automatic data_phase(input int m, input logic [3:0] len, input bit rnd);
    int beats;
    int guard;
    bit rv;
    bit last;
    bit exp_rr;
    beats = 0;
    guard = 0;
    while (beats <= int'(len) && guard < 300) begin
      rv       = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      last     = (beats == int'(len));
      RVALID   = rv;
      RLAST    = last;
      RID      = 4'(m);
      RDATA    = $urandom;
      m_rready = rnd ? N'($urandom) : '1;
      exp_rr   = m_rready[IW'(m)];
      #1;
      checkOutput("rready", 64'(RREADY), 64'(exp_rr));
      checkOutput("m_rvalid", 64'(m_rvalid), 64'(rv ? onehot(m) : '0));
      checkOutput("m_rlast", 64'(m_rlast), 64'(last ? onehot(m) : '0));
      checkOutput("m_rdata", 64'(m_rdata), 64'(RDATA));
      checkOutput("busy_data", 64'(busy), 64'(1));
      checkOutput("arvalid_in_data", 64'(ARVALID), 64'(0));
      if (rv && exp_rr) beats++;
      guard++;
      next_cycle();
    end
    checkOutput("beats_delivered", 64'(beats), 64'(int'(len) + 1));
    RVALID   = 1'b0;
    RLAST    = 1'b0;
    m_rready = '1;
    #1;
    checkOutput("busy_after_rlast", 64'(busy), 64'(0));
  endtask

  task automatic beat(input int m, input bit last, input logic [3:0] rid);
    RVALID   = 1'b1;
    RLAST    = last;
    RID      = rid;
    RDATA    = $urandom;
    m_rready = '1;
    #1;
    checkOutput("beat_rvalid", 64'(m_rvalid), 64'(onehot(m)));
    checkOutput("beat_rdata", 64'(m_rdata), 64'(RDATA));
    next_cycle();
    RVALID = 1'b0;
    RLAST  = 1'b0;
  endtask

  // Sets the round-robin pointer by completing a burst from v.prev, then
  // presents v.req and checks which master wins.
  task automatic applyStimulus(input arb_vec_t v);
    int g;
    set_req(v.prev, 32'h0000_8000, 4'd0);
    addr_phase(v.prev, 32'h0000_8000, 4'd0, 0, 1'b0);
    data_phase(v.prev, 4'd0, 1'b0);
    for (int i = 0; i < N; i++) begin
      req_addr[i] = 32'h0000_4000 + 32'(i) * 32'h100;
      req_len[i]  = 4'(i);
    end
    m_arvalid = v.req;
    g = v.exp_grant;
    addr_phase(g, 32'h0000_4000 + 32'(g) * 32'h100, 4'(g), 1, 1'b1);
    m_arvalid = '0;
    data_phase(g, 4'(g), 1'b0);
  endtask

  function automatic int model_grant();
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        d = (i - ptr_model + N) % N;
        if (d < bestd) begin
          best  = i;
          bestd = d;
        end
      end
    end
    return best;
  endfunction

  initial begin
    int pulses;
    int g;
    bit anyp;

    vecs[0] = '{prev: 3, req: 4'b1010, exp_grant: 1};
    vecs[1] = '{prev: 0, req: 4'b1010, exp_grant: 1};
    vecs[2] = '{prev: 1, req: 4'b1010, exp_grant: 3};
    vecs[3] = '{prev: 2, req: 4'b0011, exp_grant: 0};
    vecs[4] = '{prev: 3, req: 4'b1000, exp_grant: 3};
    vecs[5] = '{prev: 1, req: 4'b0100, exp_grant: 2};
    vecs[6] = '{prev: 2, req: 4'b1111, exp_grant: 3};
    vecs[7] = '{prev: 3, req: 4'b1111, exp_grant: 0};

    // Reset state, observed while rst_n is held low.
    rst_n = 1'b0;
    clear_inputs();
    next_cycle();
    next_cycle();
    #1;
    checkOutput("rst_arvalid", 64'(ARVALID), 64'(0));
    checkOutput("rst_rready", 64'(RREADY), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_rid_error", 64'(rid_error), 64'(0));
    checkOutput("rst_arid", 64'(ARID), 64'(0));
    checkOutput("rst_arlen", 64'(ARLEN), 64'(0));
    checkOutput("rst_araddr", 64'(ARADDR), 64'(0));
    checkOutput("rst_m_arready", 64'(m_arready), 64'(0));
    checkOutput("rst_m_rvalid", 64'(m_rvalid), 64'(0));
    checkOutput("rst_m_rlast", 64'(m_rlast), 64'(0));
    rst_n = 1'b1;

    // Single request with exact one-cycle grant latency and a 4-beat burst.
    set_req(0, 32'h0000_1000, 4'd3);
    ARREADY = 1'b1;
    #1;
    checkOutput("single_arvalid_early", 64'(ARVALID), 64'(0));
    next_cycle();
    #1;
    checkOutput("single_arvalid", 64'(ARVALID), 64'(1));
    checkOutput("single_arid", 64'(ARID), 64'(0));
    checkOutput("single_araddr", 64'(ARADDR), 64'h1000);
    checkOutput("single_arlen", 64'(ARLEN), 64'(3));
    checkOutput("single_m_arready", 64'(m_arready), 64'(4'b0001));
    next_cycle();
    m_arvalid = '0;
    ARREADY   = 1'b0;
    pulses    = 0;
    for (int b = 0; b < 4; b++) begin
      RVALID = 1'b1;
      RLAST  = (b == 3);
      RID    = 4'd0;
      RDATA  = 32'hA000_0000 + 32'(b);
      #1;
      if (m_rvalid[0] === 1'b1) pulses++;
      checkOutput("single_m_rlast", 64'(m_rlast[0]), 64'(b == 3));
      checkOutput("single_busy", 64'(busy), 64'(1));
      next_cycle();
    end
    RVALID = 1'b0;
    RLAST  = 1'b0;
    #1;
    checkOutput("single_pulses", 64'(pulses), 64'(4));
    checkOutput("single_busy_fall", 64'(busy), 64'(0));

    // Contention from reset: masters 0 and 1 request continuously.
    reset_dut();
    set_req(0, 32'h0000_0100, 4'd0);
    set_req(1, 32'h0000_0200, 4'd0);
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      addr_phase(g, (g == 0) ? 32'h0000_0100 : 32'h0000_0200, 4'd0, 1, 1'b1);
      data_phase(g, 4'd0, 1'b0);
    end
    m_arvalid = '0;
    next_cycle();

    // AR backpressure for 5 cycles; the master scribbles its request meanwhile.
    set_req(0, 32'h0000_2000, 4'd2);
    next_cycle();
    req_addr[0] = 32'hDEAD_0000;
    req_len[0]  = 4'hF;
    addr_phase(0, 32'h0000_2000, 4'd2, 5, 1'b0);
    // R backpressure: one beat, three stalled cycles, then the remaining two.
    beat(0, 1'b0, 4'd0);
    for (int s = 0; s < 3; s++) begin
      RVALID   = 1'b1;
      RLAST    = 1'b0;
      RDATA    = 32'h5A5A_0001;
      m_rready = 4'b1110;
      #1;
      checkOutput("rstall_rready", 64'(RREADY), 64'(0));
      checkOutput("rstall_m_rvalid", 64'(m_rvalid), 64'(4'b0001));
      checkOutput("rstall_busy", 64'(busy), 64'(1));
      next_cycle();
    end
    beat(0, 1'b0, 4'd0);
    beat(0, 1'b1, 4'd0);
    #1;
    checkOutput("rstall_done", 64'(busy), 64'(0));

    // Late arrival: master 1 requests during master 0's DATA phase.
    set_req(0, 32'h0000_3000, 4'd1);
    addr_phase(0, 32'h0000_3000, 4'd1, 0, 1'b0);
    set_req(1, 32'h0000_3100, 4'd0);
    #1;
    checkOutput("late_no_grant_d0", 64'(ARVALID), 64'(0));
    beat(0, 1'b0, 4'd0);
    #1;
    checkOutput("late_no_grant_d1", 64'(ARVALID), 64'(0));
    beat(0, 1'b1, 4'd0);
    #1;
    checkOutput("late_idle_arvalid", 64'(ARVALID), 64'(0));
    checkOutput("late_idle_busy", 64'(busy), 64'(0));
    next_cycle();
    #1;
    checkOutput("late_grant_arvalid", 64'(ARVALID), 64'(1));
    checkOutput("late_grant_arid", 64'(ARID), 64'(1));
    addr_phase(1, 32'h0000_3100, 4'd0, 0, 1'b0);
    data_phase(1, 4'd0, 1'b0);

    // RID mismatch on the first beat of a master 0 burst.
    set_req(0, 32'h0000_5000, 4'd1);
    addr_phase(0, 32'h0000_5000, 4'd1, 0, 1'b0);
    RVALID = 1'b1;
    RLAST  = 1'b0;
    RID    = 4'd1;
    RDATA  = 32'h1234_5678;
    #1;
    checkOutput("rid_beat_routed", 64'(m_rvalid), 64'(4'b0001));
    checkOutput("rid_error_before", 64'(rid_error), 64'(0));
    next_cycle();
    RID   = 4'd0;
    RLAST = 1'b1;
    #1;
    checkOutput("rid_error_set", 64'(rid_error), 64'(1));
    next_cycle();
    RVALID = 1'b0;
    RLAST  = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    checkOutput("rid_error_sticky", 64'(rid_error), 64'(1));

    // Reset in the middle of a 4-beat burst.
    reset_dut();
    set_req(0, 32'h0000_6000, 4'd3);
    addr_phase(0, 32'h0000_6000, 4'd3, 0, 1'b0);
    beat(0, 1'b0, 4'd0);
    RVALID = 1'b1;
    RDATA  = 32'hCAFE_0002;
    rst_n  = 1'b0;
    #1;
    checkOutput("midrst_beat2", 64'(m_rvalid), 64'(4'b0001));
    next_cycle();
    #1;
    checkOutput("midrst_arvalid", 64'(ARVALID), 64'(0));
    checkOutput("midrst_rready", 64'(RREADY), 64'(0));
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_m_rvalid", 64'(m_rvalid), 64'(0));
    checkOutput("midrst_arid", 64'(ARID), 64'(0));
    checkOutput("midrst_araddr", 64'(ARADDR), 64'(0));
    RVALID = 1'b0;
    rst_n  = 1'b1;
    // The pointer is back at 0, so master 0 wins over master 1.
    set_req(0, 32'h0000_7000, 4'd1);
    set_req(1, 32'h0000_7100, 4'd1);
    addr_phase(0, 32'h0000_7000, 4'd1, 0, 1'b0);
    m_arvalid = '0;
    data_phase(0, 4'd1, 1'b0);

    // Round-robin priority table.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v]);
    end

    // Randomized traffic against the request-pool model.
    reset_dut();
    ptr_model = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      anyp = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]  = 1'b1;
          paddr[i] = $urandom;
          plen[i]  = 4'($urandom_range(0, 15));
          set_req(i, paddr[i], plen[i]);
        end
        anyp = anyp | pend[i];
      end
      if (!anyp) begin
        g        = int'($urandom_range(0, N - 1));
        pend[g]  = 1'b1;
        paddr[g] = $urandom;
        plen[g]  = 4'($urandom_range(0, 15));
        set_req(g, paddr[g], plen[g]);
      end
      g = model_grant();
      addr_phase(g, paddr[g], plen[g], int'($urandom_range(0, 3)), 1'b0);
      pend[g]   = 1'b0;
      ptr_model = (g + 1) % N;
      data_phase(g, plen[g], 1'b1);
    end
    checkOutput("random_rid_error", 64'(rid_error), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
